fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: F_PC value after reset.
REQ-002 Parameter EXC_PC, default 32'h0000_4180: exception handler entry address.
REQ-003 Parameter PC_MIN, default 32'h0000_3000: lowest legal fetch address.
REQ-004 Parameter PC_MAX, default 32'h0000_6FFC: highest legal fetch address.
REQ-005 Port clk, input, 1 bit: single clock, rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port F_stall, input, 1 bit: hold the F stage this cycle.
REQ-008 Port D_valid, input, 1 bit: the D-stage instruction is real, not a bubble.
REQ-009 Port D_PC, input, 32 bits: address of the D-stage instruction.
REQ-010 Port D_offset, input, 32 bits: sign-extended branch offset, already shifted left by 2.
REQ-011 Port D_Instr_index, input, 26 bits: j/jal index field.
REQ-012 Port GRF_rs, input, 32 bits: forwarded rs value.
REQ-013 Port GRF_rt, input, 32 bits: forwarded rt value.
REQ-014 Port D_Br_type, input, 3 bits: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none).
REQ-015 Port D_Move, input, 2 bits: 00 sequential/branch, 01 j/jal, 10 jr/jalr, 11 reserved (treated as 00).
REQ-016 Port exc_req, input, 1 bit: exception redirect request.
REQ-017 Port eret_req, input, 1 bit: eret redirect request.
REQ-018 Port EPC, input, 32 bits: eret target address.
REQ-019 Port F_PC, output, 32 bits: registered current fetch address.
REQ-020 Port NPC, output, 32 bits: combinational next-PC value.
REQ-021 Port D_taken, output, 1 bit: the D-stage control transfer is taken.
REQ-022 Port F_AdEL, output, 1 bit: fetch address error for the current F_PC.

Function
REQ-023 Branch compare SHALL use signed 32-bit arithmetic on GRF_rs/GRF_rt:
- beq: rs == rt
- bne: rs != rt
- blez: rs <= 0
- bgtz: rs > 0
- bltz: rs < 0
- bgez: rs >= 0
REQ-024 D_taken SHALL be 1 iff D_valid is 1 and one of:
- D_Move = 01
- D_Move = 10
- D_Move = 00 and the selected compare is true
REQ-025 The D target SHALL be selected by transfer type:
- branch: D_PC + 4 + D_offset, modulo 2^32 (wrap-around allowed)
- j/jal: {D_PC[31:28], D_Instr_index, 2'b00}
- jr/jalr: GRF_rs
REQ-026 NPC priority SHALL be, highest first:
- exc_req: EXC_PC
- eret_req: EPC
- pending redirect valid and F_stall = 0: pending target
- D_taken and F_stall = 0: D target
- F_stall = 1: F_PC
- otherwise: F_PC + 4
REQ-027 F_PC SHALL load NPC on every rising edge of clk; latency from redirect request to F_PC update is one cycle.
REQ-028 exc_req and eret_req SHALL take effect even when F_stall = 1; when both are asserted, exc_req wins.
REQ-029 When D_taken = 1 and F_stall = 1, the D target SHALL be latched into a pending register with pend_valid set to 1.
REQ-030 The pending register SHALL be overwritten while F_stall persists.
REQ-031 The pending redirect SHALL be applied on the first cycle with F_stall = 0, and pend_valid SHALL clear on that edge.
REQ-032 exc_req or eret_req SHALL clear pend_valid on the same edge.
REQ-033 F_AdEL SHALL be 1 when any of the following holds for F_PC:
- F_PC[1:0] != 0
- F_PC < PC_MIN
- F_PC > PC_MAX
REQ-034 F_AdEL SHALL NOT alter F_PC sequencing.
REQ-035 A jr to a misaligned address SHALL be loaded into F_PC unchanged; F_AdEL then flags it.

Reset
REQ-036 While reset = 1, F_PC SHALL be RESET_PC and pend_valid SHALL be 0, independent of clk.
REQ-037 Reset asserted mid-stall or with a redirect pending SHALL discard the pending redirect.
REQ-038 The first fetch after reset deassertion SHALL be at RESET_PC, with F_AdEL = 0 for the default parameters.

Structure
REQ-039 D_Br_type codes, D_Move codes, RESET_PC and EXC_PC defaults SHALL reside in the shared macro header used by the datapath and controller.
REQ-040 The branch compare SHALL be a sub-module named branch_cmp (combinational: GRF_rs, GRF_rt, D_Br_type in; cond out).
REQ-041 The PC register and the pending register SHALL be in fetch_pc_unit itself.

Verification
REQ-042 Release reset with no stalls and no redirects -> F_PC reads 0x3000, 0x3004, 0x3008 on successive cycles.
REQ-043 beq with D_PC = 0x3010, rs = rt = 5, D_offset = 0xFFFFFFF0 -> D_taken = 1 and F_PC = 0x3004 on the next edge.
REQ-044 jal with D_PC = 0x3020 and index 0x0000C40 -> F_PC = 0x00003100.
REQ-045 bgtz with rs = 0x80000000 -> D_taken = 0, confirming the signed compare.
REQ-046 jr to 0x3050 while F_stall = 1 for 3 cycles -> F_PC holds through the stall, then becomes 0x3050 one edge after stall release.
REQ-047 exc_req and eret_req asserted together during a stall, with a redirect pending -> F_PC = 0x4180 and pend_valid = 0.
REQ-048 jr to 0x3002 -> F_PC = 0x3002 and F_AdEL = 1.
REQ-049 jr to 0x7000 -> F_AdEL = 1.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared encodings and defaults for the fetch PC unit.
// Branch compare codes, transfer-type codes, reset and exception vectors.
package fetch_pc_unit_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;

  localparam logic [1:0] MOVE_SEQ = 2'b00;
  localparam logic [1:0] MOVE_J   = 2'b01;
  localparam logic [1:0] MOVE_JR  = 2'b10;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
  localparam logic [31:0] PC_MIN_DEF   = 32'h0000_3000;
  localparam logic [31:0] PC_MAX_DEF   = 32'h0000_6FFC;

  // Fetch address error: misaligned or outside the legal window.
  function automatic logic addr_err(input logic [31:0] pc,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_branch_cmp.sv
// Signed branch condition evaluation for the D-stage instruction.
module branch_cmp
  import fetch_pc_unit_pkg::*;
(
  input  logic [31:0] GRF_rs,
  input  logic [31:0] GRF_rt,
  input  logic [2:0]  D_Br_type,
  output logic        cond
);

  logic signed [31:0] rs_s;
  assign rs_s = GRF_rs;

  always_comb begin
    cond = 1'b0;
    case (D_Br_type)
      BR_BEQ:  cond = (GRF_rs == GRF_rt);
      BR_BNE:  cond = (GRF_rs != GRF_rt);
      BR_BLEZ: cond = (rs_s <= 32'sd0);
      BR_BGTZ: cond = (rs_s >  32'sd0);
      BR_BLTZ: cond = (rs_s <  32'sd0);
      BR_BGEZ: cond = (rs_s >= 32'sd0);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register with redirect selection and a pending slot that
// holds a D-stage redirect across F-stage stalls.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
  parameter logic [31:0] PC_MIN   = PC_MIN_DEF,
  parameter logic [31:0] PC_MAX   = PC_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_stall,
  input  logic        D_valid,
  input  logic [31:0] D_PC,
  input  logic [31:0] D_offset,
  input  logic [25:0] D_Instr_index,
  input  logic [31:0] GRF_rs,
  input  logic [31:0] GRF_rt,
  input  logic [2:0]  D_Br_type,
  input  logic [1:0]  D_Move,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] EPC,
  output logic [31:0] F_PC,
  output logic [31:0] NPC,
  output logic        D_taken,
  output logic        F_AdEL
);

  logic [31:0] pc_reg;
  logic        pend_valid_reg;
  logic [31:0] pend_target_reg;
  logic        cond;
  logic [31:0] d_target;

  branch_cmp u_branch_cmp (
    .GRF_rs    (GRF_rs),
    .GRF_rt    (GRF_rt),
    .D_Br_type (D_Br_type),
    .cond      (cond)
  );

  // Reserved move code 11 behaves like a sequential/branch instruction.
  always_comb begin
    d_target = D_PC + 32'd4 + D_offset;
    D_taken  = D_valid & cond;
    case (D_Move)
      MOVE_J: begin
        d_target = {D_PC[31:28], D_Instr_index, 2'b00};
        D_taken  = D_valid;
      end
      MOVE_JR: begin
        d_target = GRF_rs;
        D_taken  = D_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (exc_req)
      NPC = EXC_PC;
    else if (eret_req)
      NPC = EPC;
    else if (pend_valid_reg && !F_stall)
      NPC = pend_target_reg;
    else if (D_taken && !F_stall)
      NPC = d_target;
    else if (F_stall)
      NPC = pc_reg;
    else
      NPC = pc_reg + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
    end else begin
      pc_reg <= NPC;
      if (exc_req || eret_req) begin
        pend_valid_reg <= 1'b0;
      end else if (F_stall) begin
        // Latest D redirect during a stall replaces any earlier one.
        if (D_taken) begin
          pend_valid_reg  <= 1'b1;
          pend_target_reg <= d_target;
        end
      end else begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  assign F_PC   = pc_reg;
  assign F_AdEL = addr_err(pc_reg, PC_MIN, PC_MAX);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus queues expected values tagged
// with the cycle they apply to; a negedge monitor pops and compares them.
module tb_fetch_pc_unit;

    localparam int SIG_FPC  = 0;
    localparam int SIG_NPC  = 1;
    localparam int SIG_TKN  = 2;
    localparam int SIG_ADEL = 3;
    localparam int SIG_PEND = 4;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        F_stall;
    logic        D_valid;
    logic [31:0] D_PC;
    logic [31:0] D_offset;
    logic [25:0] D_Instr_index;
    logic [31:0] GRF_rs;
    logic [31:0] GRF_rt;
    logic [2:0]  D_Br_type;
    logic [1:0]  D_Move;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] EPC;
    logic [31:0] F_PC;
    logic [31:0] NPC;
    logic        D_taken;
    logic        F_AdEL;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    fetch_pc_unit u_dut (
        .clk           (clk),
        .reset         (reset),
        .F_stall       (F_stall),
        .D_valid       (D_valid),
        .D_PC          (D_PC),
        .D_offset      (D_offset),
        .D_Instr_index (D_Instr_index),
        .GRF_rs        (GRF_rs),
        .GRF_rt        (GRF_rt),
        .D_Br_type     (D_Br_type),
        .D_Move        (D_Move),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .EPC           (EPC),
        .F_PC          (F_PC),
        .NPC           (NPC),
        .D_taken       (D_taken),
        .F_AdEL        (F_AdEL)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            SIG_FPC:  return F_PC;
            SIG_NPC:  return NPC;
            SIG_TKN:  return {31'd0, D_taken};
            SIG_ADEL: return {31'd0, F_AdEL};
            default:  return {31'd0, u_dut.pend_valid_reg};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [31:0] a;
                a = actual(sb[i].sig);
                n_checks++;
                if (a === sb[i].val) begin
                    n_pass++;
                    $display("cyc %0d %s: got %h ok", cyc, sb[i].name, a);
                end else begin
                    $display("FAIL %s: cyc %0d got %h expected %h", sb[i].name, cyc, a, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int off, input int sig, input logic [31:0] val,
                             input string name);
        exp_t e;
        e.cyc  = cyc + off;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d_none();
        D_valid = 1'b0; D_Move = 2'b00; D_Br_type = 3'd0;
    endtask

    task automatic d_jr(input logic [31:0] tgt);
        D_valid = 1'b1; D_Move = 2'b10; D_Br_type = 3'd0; GRF_rs = tgt;
    endtask

    initial begin
        reset = 1'b1; F_stall = 1'b0; D_valid = 1'b0; D_PC = '0; D_offset = '0;
        D_Instr_index = '0; GRF_rs = '0; GRF_rt = '0; D_Br_type = '0; D_Move = '0;
        exc_req = 1'b0; eret_req = 1'b0; EPC = '0;

        step();
        expect_at(0, SIG_FPC, 32'h3000, "reset_fpc");
        expect_at(0, SIG_PEND, 32'd0, "reset_pend");
        step();
        reset = 1'b0;
        n_checks++;
        if (F_PC === 32'h3000) begin
            n_pass++;
            $display("cyc %0d direct_first_fetch: got %h ok", cyc, F_PC);
        end else begin
            $display("FAIL direct_first_fetch: cyc %0d got %h expected %h", cyc, F_PC, 32'h3000);
        end
        expect_at(0, SIG_FPC, 32'h3000, "first_fetch");
        expect_at(0, SIG_ADEL, 32'd0, "first_adel");
        expect_at(0, SIG_NPC, 32'h3004, "first_npc");
        expect_at(1, SIG_FPC, 32'h3004, "seq_3004");
        expect_at(2, SIG_FPC, 32'h3008, "seq_3008");
        step();
        step();

        D_valid = 1'b1; D_Move = 2'b00; D_Br_type = 3'd1; D_PC = 32'h3010;
        GRF_rs = 32'd5; GRF_rt = 32'd5; D_offset = 32'hFFFF_FFF0;
        expect_at(0, SIG_TKN, 32'd1, "beq_taken");
        expect_at(0, SIG_NPC, 32'h3004, "beq_npc");
        expect_at(1, SIG_FPC, 32'h3004, "beq_fpc");
        step();
        D_Br_type = 3'd2;
        expect_at(0, SIG_TKN, 32'd0, "bne_not_taken");
        expect_at(0, SIG_NPC, 32'h3008, "bne_npc");
        expect_at(1, SIG_FPC, 32'h3008, "bne_fpc");
        step();
        D_Move = 2'b01; D_Br_type = 3'd0; D_PC = 32'h3020; D_Instr_index = 26'h0000C40;
        expect_at(0, SIG_TKN, 32'd1, "jal_taken");
        expect_at(1, SIG_FPC, 32'h3100, "jal_fpc");
        step();
        n_checks++;
        if (F_PC === 32'h3100) begin
            n_pass++;
            $display("cyc %0d direct_jal_fpc: got %h ok", cyc, F_PC);
        end else begin
            $display("FAIL direct_jal_fpc: cyc %0d got %h expected %h", cyc, F_PC, 32'h3100);
        end
        D_Move = 2'b00; D_Br_type = 3'd4; GRF_rs = 32'h8000_0000;
        expect_at(0, SIG_TKN, 32'd0, "bgtz_signed");
        expect_at(1, SIG_FPC, 32'h3104, "bgtz_fpc");
        step();
        D_Br_type = 3'd5; D_PC = 32'h3104; D_offset = 32'd8;
        expect_at(0, SIG_TKN, 32'd1, "bltz_signed");
        expect_at(1, SIG_FPC, 32'h3110, "bltz_fpc");
        step();
        D_valid = 1'b0; D_Move = 2'b01;
        expect_at(0, SIG_TKN, 32'd0, "bubble_not_taken");
        expect_at(1, SIG_FPC, 32'h3114, "bubble_fpc");
        step();

        F_stall = 1'b1; d_jr(32'h3050);
        expect_at(0, SIG_TKN, 32'd1, "jr_stall_taken");
        expect_at(0, SIG_NPC, 32'h3114, "jr_stall_npc");
        expect_at(1, SIG_FPC, 32'h3114, "stall1_fpc");
        expect_at(1, SIG_PEND, 32'd1, "stall1_pend");
        expect_at(2, SIG_FPC, 32'h3114, "stall2_fpc");
        expect_at(3, SIG_FPC, 32'h3114, "stall3_fpc");
        step();
        step();
        step();
        F_stall = 1'b0; d_none();
        expect_at(0, SIG_NPC, 32'h3050, "pend_npc");
        expect_at(1, SIG_FPC, 32'h3050, "pend_fpc");
        expect_at(1, SIG_PEND, 32'd0, "pend_clear");
        step();
        n_checks++;
        if (F_PC === 32'h3050) begin
            n_pass++;
            $display("cyc %0d direct_pend_fpc: got %h ok", cyc, F_PC);
        end else begin
            $display("FAIL direct_pend_fpc: cyc %0d got %h expected %h", cyc, F_PC, 32'h3050);
        end

        F_stall = 1'b1; d_jr(32'h3060);
        step();
        GRF_rs = 32'h3070;
        step();
        F_stall = 1'b0; d_none();
        expect_at(1, SIG_FPC, 32'h3070, "pend_overwrite");
        step();

        F_stall = 1'b1; d_jr(32'h3080);
        expect_at(1, SIG_PEND, 32'd1, "exc_pre_pend");
        step();
        exc_req = 1'b1; eret_req = 1'b1; EPC = 32'h5000;
        expect_at(0, SIG_NPC, 32'h4180, "exc_npc");
        expect_at(1, SIG_FPC, 32'h4180, "exc_fpc");
        expect_at(1, SIG_PEND, 32'd0, "exc_pend_clear");
        step();
        exc_req = 1'b0; eret_req = 1'b0; F_stall = 1'b0; d_none();
        expect_at(0, SIG_NPC, 32'h4184, "post_exc_npc");
        step();
        eret_req = 1'b1; EPC = 32'h3200;
        expect_at(1, SIG_FPC, 32'h3200, "eret_fpc");
        step();
        eret_req = 1'b0;

        d_jr(32'h3002);
        expect_at(1, SIG_FPC, 32'h3002, "misalign_fpc");
        expect_at(1, SIG_ADEL, 32'd1, "misalign_adel");
        step();
        n_checks++;
        if (F_AdEL === 1'b1) begin
            n_pass++;
            $display("cyc %0d direct_misalign_adel: got %b ok", cyc, F_AdEL);
        end else begin
            $display("FAIL direct_misalign_adel: cyc %0d got %b expected 1", cyc, F_AdEL);
        end
        d_none();
        expect_at(1, SIG_FPC, 32'h3006, "misalign_seq");
        step();
        d_jr(32'h7000);
        expect_at(1, SIG_ADEL, 32'd1, "above_max_adel");
        step();
        GRF_rs = 32'h6FFC;
        expect_at(1, SIG_ADEL, 32'd0, "at_max_adel");
        step();
        GRF_rs = 32'h2FFC;
        expect_at(1, SIG_ADEL, 32'd1, "below_min_adel");
        step();

        F_stall = 1'b1; d_jr(32'h3300);
        step();
        #1;
        reset = 1'b1;
        expect_at(0, SIG_FPC, 32'h3000, "async_reset_fpc");
        expect_at(0, SIG_PEND, 32'd0, "async_reset_pend");
        step();
        reset = 1'b0; F_stall = 1'b0; d_none();
        expect_at(0, SIG_FPC, 32'h3000, "rerun_fpc");
        expect_at(1, SIG_FPC, 32'h3004, "rerun_seq");
        step();
        step();
        step();

        foreach (sb[i]) begin
            n_checks++;
            $display("FAIL %s: never checked, expected %h at cyc %0d", sb[i].name, sb[i].val, sb[i].cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        if (n_pass == n_checks)
            $display("PASS");
        else
            $display("FAIL %0d checks failed", n_checks - n_pass);
        $finish;
    end

endmodule
